// File: rtl/seg_pipeline_adder_pkg.sv
// Shared constants and helpers for the segmented pipeline adder.
// Also provides the width/segment sanity checks used by DDSM datapath blocks.
package seg_adder_pkg;

    localparam int SEG_DW_DEFAULT   = 24;
    localparam int SEG_SEGS_DEFAULT = 4;

    // Width of one segment.
    function automatic int seg_width(input int dw, input int segs);
        return dw / segs;
    endfunction

    // Legal configuration: 1..dw segments that divide dw exactly.
    function automatic bit seg_cfg_ok(input int dw, input int segs);
        return (segs >= 1) && (segs <= dw) && ((dw % segs) == 0);
    endfunction

    localparam bit SEG_DEFAULT_CFG_OK =
        seg_cfg_ok(SEG_DW_DEFAULT, SEG_SEGS_DEFAULT);

endpackage

// File: rtl/seg_pipeline_adder_if.sv
// Valid/ready operand and result bundle for seg_pipeline_adder.
// Optional macro SEG_PIPELINE_ADDER_SUB_EN adds the i_sub beat field.
interface seg_pipeline_adder_if #(
    parameter int P_DATA_WIDTH = 24
) ();

    logic                    i_valid;
    logic                    o_ready;
    logic [P_DATA_WIDTH-1:0] i_a;
    logic [P_DATA_WIDTH-1:0] i_b;
    logic                    i_cin;
`ifdef SEG_PIPELINE_ADDER_SUB_EN
    logic                    i_sub;
`endif
    logic                    o_valid;
    logic                    i_ready;
    logic [P_DATA_WIDTH-1:0] o_sum;
    logic                    o_cout;

    modport master (
`ifdef SEG_PIPELINE_ADDER_SUB_EN
        output i_sub,
`endif
        output i_valid, i_a, i_b, i_cin, i_ready,
        input  o_ready, o_valid, o_sum, o_cout
    );

    modport slave (
`ifdef SEG_PIPELINE_ADDER_SUB_EN
        input  i_sub,
`endif
        input  i_valid, i_a, i_b, i_cin, i_ready,
        output o_ready, o_valid, o_sum, o_cout
    );

endinterface

// File: rtl/seg_pipeline_adder_cell.sv
// One W-bit segment adder: {cout, sum} = a + b + cin.
// Purely combinational; the top registers around it.
module seg_adder_cell
    import seg_adder_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/seg_pipeline_adder.sv
// S-stage carry-pipelined adder with skew/deskew triangles and bubble collapse.
// Optional macro SEG_PIPELINE_ADDER_SUB_EN adds per-beat subtract (a + ~b + 1).
module seg_pipeline_adder
    import seg_adder_pkg::*;
#(
    parameter int P_DATA_WIDTH = SEG_DW_DEFAULT,
    parameter int P_SEGS       = SEG_SEGS_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_rst,
    seg_pipeline_adder_if.slave bus
);

    localparam int W  = seg_width(P_DATA_WIDTH, P_SEGS);
    localparam int DW = P_DATA_WIDTH;
    localparam int S  = P_SEGS;

    if (!seg_cfg_ok(P_DATA_WIDTH, P_SEGS)) begin : g_cfg_err
        $error("seg_pipeline_adder: P_DATA_WIDTH must be a multiple of P_SEGS");
    end

    logic [S-1:0]  v_q;
    logic [S-1:0]  v_in;
    logic [S-1:0]  adv;
    logic          run;
    logic [DW-1:0] sum_q;
    logic          cout_q;

    if (S == 1) begin : g_vin1
        assign v_in = bus.i_valid;
    end else begin : g_vinn
        assign v_in = {v_q[S-2:0], bus.i_valid};
    end

    // A stage may load when it is empty or everything below it can move.
    always_comb begin
        run = bus.i_ready;
        adv = '0;
        for (int k = S - 1; k >= 0; k--) begin
            run    = run | ~v_q[k];
            adv[k] = run;
        end
    end

    // Valid bits shift down the pipe wherever the stage advances.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_in[k];
                end
            end
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int IW = DW - k * W;

        logic [IW-1:0]        a_in;
        logic [IW-1:0]        b_in;
        logic                 cin_in;
        logic [W-1:0]         b_seg;
        logic [W-1:0]         seg_sum;
        logic                 seg_cout;
        logic [(k+1)*W-1:0]   sum_acc;
`ifdef SEG_PIPELINE_ADDER_SUB_EN
        logic                 sub_in;
`endif

        if (k == 0) begin : g_head
            assign a_in    = bus.i_a;
            assign b_in    = bus.i_b;
`ifdef SEG_PIPELINE_ADDER_SUB_EN
            assign sub_in  = bus.i_sub;
            assign cin_in  = bus.i_sub | bus.i_cin;
`else
            assign cin_in  = bus.i_cin;
`endif
            assign sum_acc = seg_sum;
        end else begin : g_body
            localparam int PW = IW + W;

            logic [IW-1:0]     a_q;
            logic [IW-1:0]     b_q;
            logic              cy_q;
            logic [k*W-1:0]    sum_lo_q;
`ifdef SEG_PIPELINE_ADDER_SUB_EN
            logic              sub_q;
`endif

            // Register of stage k-1: remaining operand segs, carry, low sum segs.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    a_q      <= '0;
                    b_q      <= '0;
                    cy_q     <= 1'b0;
                    sum_lo_q <= '0;
`ifdef SEG_PIPELINE_ADDER_SUB_EN
                    sub_q    <= 1'b0;
`endif
                end else if (adv[k-1]) begin
                    a_q      <= g_stage[k-1].a_in[PW-1:W];
                    b_q      <= g_stage[k-1].b_in[PW-1:W];
                    cy_q     <= g_stage[k-1].seg_cout;
                    sum_lo_q <= g_stage[k-1].sum_acc;
`ifdef SEG_PIPELINE_ADDER_SUB_EN
                    sub_q    <= g_stage[k-1].sub_in;
`endif
                end
            end

            assign a_in    = a_q;
            assign b_in    = b_q;
            assign cin_in  = cy_q;
`ifdef SEG_PIPELINE_ADDER_SUB_EN
            assign sub_in  = sub_q;
`endif
            assign sum_acc = {seg_sum, sum_lo_q};
        end

`ifdef SEG_PIPELINE_ADDER_SUB_EN
        assign b_seg = sub_in ? ~b_in[W-1:0] : b_in[W-1:0];
`else
        assign b_seg = b_in[W-1:0];
`endif

        seg_adder_cell #(
            .W(W)
        ) u_cell (
            .a_i   (a_in[W-1:0]),
            .b_i   (b_seg),
            .cin_i (cin_in),
            .sum_o (seg_sum),
            .cout_o(seg_cout)
        );
    end

    // Last stage register: fully deskewed sum and carry-out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (adv[S-1]) begin
            sum_q  <= g_stage[S-1].sum_acc;
            cout_q <= g_stage[S-1].seg_cout;
        end
    end

    assign bus.o_ready = adv[0];
    assign bus.o_valid = v_q[S-1];
    assign bus.o_sum   = sum_q;
    assign bus.o_cout  = cout_q;

endmodule

// File: tb/tb_seg_pipeline_adder.sv
// Scoreboard bench for seg_pipeline_adder (DW=16, SEGS=4).
// Optional macro SEG_PIPELINE_ADDER_SUB_EN enables subtract stimulus.
module tb_seg_pipeline_adder;

    localparam int DW = 16;
    localparam int S  = 4;

    typedef struct packed {
        logic [DW-1:0] sum;
        logic          cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg_pipeline_adder_if #(.P_DATA_WIDTH(DW)) bus ();

    seg_pipeline_adder #(
        .P_DATA_WIDTH(DW),
        .P_SEGS      (S)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    exp_t          sbq[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            pops        = 0;
    logic          held_v      = 1'b0;
    logic [DW-1:0] held_sum;
    logic          held_cout;
    exp_t          mon_e;
    logic          cur_sub;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer add, or a-b with no-borrow flag.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic cin, input logic sub);
        int unsigned ua;
        int unsigned ub;
        int unsigned t;
        exp_t        e;
        ua = a;
        ub = b;
        if (sub) begin
            t      = ua - ub;
            e.sum  = t[DW-1:0];
            e.cout = (ua >= ub);
        end else begin
            t      = ua + ub + cin;
            e.sum  = t[DW-1:0];
            e.cout = t[DW];
        end
        return e;
    endfunction

    // Monitor: handshake model, stall stability, in-order result check.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            held_v = 1'b0;
        end else begin
            check("o_ready", bus.o_ready, (sbq.size() < S) || bus.i_ready);
            if (bus.o_valid) begin
                if (held_v) begin
                    check("hold_sum", bus.o_sum, held_sum);
                    check("hold_cout", bus.o_cout, held_cout);
                end
                if (bus.i_ready) begin
                    if (sbq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got sum %0h expected no beat",
                                 bus.o_sum);
                    end else begin
                        mon_e = sbq.pop_front();
                        check("sum", bus.o_sum, mon_e.sum);
                        check("cout", bus.o_cout, mon_e.cout);
                    end
                    pops++;
                    held_v = 1'b0;
                end else begin
                    held_v    = 1'b1;
                    held_sum  = bus.o_sum;
                    held_cout = bus.o_cout;
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                sbq.push_back(model(bus.i_a, bus.i_b, bus.i_cin, cur_sub));
            end
        end
    end

`ifdef SEG_PIPELINE_ADDER_SUB_EN
    assign cur_sub = bus.i_sub;
`else
    assign cur_sub = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic cin, input logic sub);
        bus.i_a   = a;
        bus.i_b   = b;
        bus.i_cin = cin;
`ifdef SEG_PIPELINE_ADDER_SUB_EN
        bus.i_sub = sub;
`else
        if (sub) bus.i_cin = cin;
`endif
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic cin, input logic sub);
        logic acc;
        int   n;
        drive(a, b, cin, sub);
        bus.i_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.o_ready;
            step();
            n++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
        bus.i_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        int   lat;
        int   acc_cnt;
        int   p0;
        int   n;
        logic acc;
        logic sb;

        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_cin   = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
`ifdef SEG_PIPELINE_ADDER_SUB_EN
        bus.i_sub   = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_o_sum", bus.o_sum, 0);
        check("rst_o_cout", bus.o_cout, 0);
        check("rst_o_ready", bus.o_ready, 1);

        // Carry ripples through all four segments.
        bus.i_ready = 1'b1;
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        lat = 1;
        while (!bus.o_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", lat, S);
        check("carry_sum", bus.o_sum, 16'h0000);
        check("carry_cout", bus.o_cout, 1);
        repeat (2) step();

        // Streaming: 8 back-to-back beats.
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            send(rnd_op(), rnd_op(), 1'($urandom), 1'b0);
        end
        repeat (4) step();
        check("stream_pops", pops - p0, 8);

        // Backpressure: continuous valid with output stalled.
        bus.i_ready = 1'b0;
        acc_cnt = 0;
        drive(rnd_op(), rnd_op(), 1'($urandom), 1'b0);
        bus.i_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = bus.o_ready;
            step();
            if (acc) begin
                acc_cnt++;
                drive(rnd_op(), rnd_op(), 1'($urandom), 1'b0);
            end
        end
        check("bp_accepts", acc_cnt, S);
        bus.i_ready = 1'b1;
        send(bus.i_a, bus.i_b, bus.i_cin, 1'b0);
        repeat (8) step();

        // Bubble collapse: gapped beats queued behind a stall.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(rnd_op(), rnd_op(), 1'($urandom), 1'b0);
            repeat (2) step();
        end
        bus.i_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("collapse_valid", bus.o_valid, 1);
            step();
        end
        repeat (4) step();

        // Reset with three beats in flight.
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(rnd_op() | 16'h0100, rnd_op(), 1'b1, 1'b0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_o_valid", bus.o_valid, 0);
        check("mid_rst_o_sum", bus.o_sum, 0);
        check("mid_rst_o_ready", bus.o_ready, 1);
        bus.i_ready = 1'b1;
        repeat (8) step();

`ifdef SEG_PIPELINE_ADDER_SUB_EN
        // Subtract with borrow; i_cin must be ignored.
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        n = 0;
        while (!bus.o_valid && n < 20) begin
            step();
            n++;
        end
        check("sub_sum", bus.o_sum, 16'hFFFE);
        check("sub_cout", bus.o_cout, 0);
        repeat (4) step();
`endif

        // Random traffic with random backpressure and gaps.
        for (int c = 0; c < 600; c++) begin
            bus.i_ready = ($urandom_range(0, 3) != 0);
            if (!bus.i_valid && $urandom_range(0, 2) != 0) begin
`ifdef SEG_PIPELINE_ADDER_SUB_EN
                sb = 1'($urandom);
`else
                sb = 1'b0;
`endif
                drive(rnd_op(), rnd_op(), 1'($urandom), sb);
                bus.i_valid = 1'b1;
            end
            @(negedge clk);
            acc = bus.i_valid && bus.o_ready;
            step();
            if (acc) bus.i_valid = 1'b0;
        end
        bus.i_valid = 1'b0;

        // Drain: every accepted beat must come out exactly once.
        bus.i_ready = 1'b1;
        n = 0;
        while (sbq.size() > 0 && n < 50) begin
            step();
            n++;
        end
        repeat (2) step();
        check("drain_empty", sbq.size(), 0);
        check("drain_o_valid", bus.o_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
